// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the CPU's program-mode RAM port.
// Receives 8N1 UART bytes, decodes a load packet (0xA5, LEN, payload) and
// writes each payload byte to RAM as an address strobe followed by a data strobe.
// The core is held in program mode while a load is in progress.
// Optional feature: define PROG_LOADER_CSUM_EN to add a trailing checksum byte
// (8-bit sum of the payload). A mismatch aborts the load with error.
// Handshake: rx_valid / rx_ferr are single-cycle pulses from the receiver and
// carry no back-pressure. The byte spacing on the line guarantees that the write
// sequence has finished before the next pulse arrives. pm_addr_we and pm_data_we
// are single-cycle strobes that the RAM must capture on the next clock edge.
module prog_loader #(
  parameter int         CLKS_PER_BIT = 217,
  parameter logic [7:0] BASE_ADDR    = 8'h00
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       program_mode,
  output logic       pm_addr_we,
  output logic [7:0] pm_address,
  output logic       pm_data_we,
  output logic [7:0] pm_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] dbg_state
);

  localparam int         CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_DATA    = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4,
`ifdef PROG_LOADER_CSUM_EN
    S_CSUM    = 3'd7,
`endif
    S_FIN     = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            r_rx_prev;
  rx_state_t       r_rx_state;
  rx_state_t       w_rx_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_rx_valid;
  logic            r_rx_ferr;
  logic            w_bit_end;
  logic            w_half_end;

  assign w_bit_end  = (r_cnt == BIT_LAST);
  assign w_half_end = (r_cnt == HALF_LAST);

  // Two-flop synchroniser plus previous-value register for falling-edge detection
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) r_rx_state <= RX_IDLE;
    else      r_rx_state <= w_rx_next;
  end

  // Receiver next state: start re-checked at half bit, data and stop sampled mid-bit
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
      RX_START: if (w_half_end) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_end) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Receiver datapath: bit timer, bit index, LSB-first shift, result pulses
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if ((r_rx_state == RX_IDLE) || (w_rx_next != r_rx_state)) begin
        r_cnt <= '0;
      end else if (w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_rx_state == RX_START) begin
        r_bit_idx <= 3'd0;
      end
      if ((r_rx_state == RX_DATA) && w_bit_end) begin
        r_shift   <= {r_rx_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_rx_state == RX_STOP) && w_bit_end) begin
        r_rx_valid <= r_rx_sync;
        r_rx_ferr  <= ~r_rx_sync;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_len;
  logic [7:0]  r_idx;
  logic [7:0]  r_pm_address;
  logic [7:0]  r_pm_data;
  logic        r_done;
  logic        r_error;
  logic        w_last;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]  r_sum;
`endif

  // LEN of 0 encodes 256: r_len - 1 wraps to 0xFF, matching the final index
  assign w_last = (r_idx == (r_len - 8'd1));

  // Packet state register
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Packet next state: sync hunt in IDLE only, framing errors abort an active load
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_rx_valid && (r_shift == SYNC_BYTE)) w_state_next = S_LEN;
      end
      S_LEN: begin
        if (r_rx_ferr)       w_state_next = S_ERR;
        else if (r_rx_valid) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (r_rx_ferr)       w_state_next = S_ERR;
        else if (r_rx_valid) w_state_next = S_WR_ADDR;
      end
      S_WR_ADDR: w_state_next = S_WR_DATA;
      S_WR_DATA: begin
        if (w_last) begin
`ifdef PROG_LOADER_CSUM_EN
          w_state_next = S_CSUM;
`else
          w_state_next = S_FIN;
`endif
        end else begin
          w_state_next = S_DATA;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM: begin
        if (r_rx_ferr)       w_state_next = S_ERR;
        else if (r_rx_valid) w_state_next = (r_shift == r_sum) ? S_FIN : S_ERR;
      end
`endif
      S_FIN:   w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Packet datapath: length, index, write address/data, status levels, running sum
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_len        <= 8'h00;
      r_idx        <= 8'h00;
      r_pm_address <= 8'h00;
      r_pm_data    <= 8'h00;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      r_sum        <= 8'h00;
`endif
    end else begin
      if ((r_state == S_IDLE) && (w_state_next == S_LEN)) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      if (w_state_next == S_FIN) r_done  <= 1'b1;
      if (w_state_next == S_ERR) r_error <= 1'b1;
      if ((r_state == S_LEN) && r_rx_valid) begin
        r_len <= r_shift;
        r_idx <= 8'h00;
`ifdef PROG_LOADER_CSUM_EN
        r_sum <= 8'h00;
`endif
      end
      if ((r_state == S_DATA) && r_rx_valid) begin
        r_pm_data    <= r_shift;
        r_pm_address <= BASE_ADDR + r_idx;
`ifdef PROG_LOADER_CSUM_EN
        r_sum        <= r_sum + r_shift;
`endif
      end
      if (r_state == S_WR_DATA) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  // Outputs decode directly from the state register, so reset clears them at once
  assign program_mode = (r_state == S_LEN) || (r_state == S_DATA) ||
                        (r_state == S_WR_ADDR) || (r_state == S_WR_DATA)
`ifdef PROG_LOADER_CSUM_EN
                        || (r_state == S_CSUM)
`endif
                        ;
  assign busy       = program_mode;
  assign pm_addr_we = (r_state == S_WR_ADDR);
  assign pm_data_we = (r_state == S_WR_DATA);
  assign pm_address = r_pm_address;
  assign pm_data    = r_pm_data;
  assign done       = r_done;
  assign error      = r_error;
  assign dbg_state  = r_state;

endmodule
